// File: rtl/init_seq_pkg.sv
// Purpose: shared types and constants for the power-up init sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package init_seq_pkg;

  // Width of every delay / timeout counter in the sequencer.
  localparam int CNT_W = 16;

  // Encodings are exported on the debug state port; keep them stable.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    READY  = 3'd4,
    ERROR  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/delay_timer.sv
// Purpose: loadable 16-bit down counter shared by power-up delay, settle delay and stage timeout.
// Latency: load takes effect on the next edge; expire is combinational from the count register.
// Backpressure: none; enable simply pauses the count, which saturates at zero instead of wrapping.
//
// Ports: clk, reset_n (sync, active-low), load/load_val (restart count), enable (count down),
//        expire (count is zero).
module delay_timer
  import init_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/init_sequencer.sv
// Purpose: gated power-up sequencer walking handshaked init stages, with per-stage timeout and retry.
// Latency: all outputs registered; one cycle from any sampled input to its effect on the outputs.
// Backpressure: none; stage_done is a level sampled only while that stage is enabled.
//
// Ports: clk, reset_n (sync, active-low), pll_lock (gate), retry (pulse, acts only in ERROR),
//        stage_done/stage_en (per-stage handshake), stage_reset_n, system_ready, error,
//        error_stage (index of timed-out stage), state (debug encoding).
module init_sequencer
  import init_seq_pkg::*;
#(
  parameter int                    NUM_STAGES    = 3,
  parameter int                    POWERUP_DELAY = 32,
  parameter int                    SETTLE_DELAY  = 32,
  parameter int                    TIMEOUT       = 1000,
  parameter logic [NUM_STAGES-1:0] STAGE_SKIP    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  retry,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  stage_reset_n,
  output logic                  system_ready,
  output logic                  error,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] error_stage,
  output logic [2:0]            state
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // The timer counts down to zero and the FSM acts on the edge where it reads zero,
  // so an N-cycle wait loads N-1.
  localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(POWERUP_DELAY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = (SETTLE_DELAY == 0) ? '0 : CNT_W'(SETTLE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = (TIMEOUT == 0)     ? '0 :
                                              (TIMEOUT > 65536)  ? '1 : CNT_W'(TIMEOUT - 1);

  seq_state_t              state_q, state_n;
  logic [SW-1:0]           cur_q, cur_n;
  logic [NUM_STAGES-1:0]   en_n;
  logic                    err_n;
  logic [SW-1:0]           est_n;
  logic                    tmr_load, tmr_en, tmr_expire;
  logic [CNT_W-1:0]        tmr_val;
  logic                    done_hit;
  logic [SW:0]             first_stg, next_stg;

  // Lowest non-skipped stage at or above 'from'; MSB flags that one exists.
  function automatic logic [SW:0] find_stage(input logic [SW:0] from);
    logic [SW:0]           r;
    logic [NUM_STAGES-1:0] sk;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      sk = STAGE_SKIP >> i;
      if ((i >= int'(from)) && !sk[0]) r = {1'b1, SW'(i)};
    end
    return r;
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [SW-1:0] idx);
    return NUM_STAGES'(1) << idx;
  endfunction

  delay_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_en),
    .expire   (tmr_expire)
  );

  assign tmr_en = (state_q == DELAY) || (state_q == RUN) || (state_q == SETTLE);

  always_comb begin
    state_n   = state_q;
    cur_n     = cur_q;
    en_n      = stage_en;
    err_n     = error;
    est_n     = error_stage;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    // stage_en is one-hot-or-zero, so this only sees the active stage's done bit.
    done_hit  = |(stage_en & stage_done);
    first_stg = find_stage('0);
    next_stg  = find_stage({1'b0, cur_q} + (SW+1)'(1));

    if (!pll_lock && (state_q != IDLE)) begin
      // Loss of lock beats everything else; the error flag survives for diagnosis.
      state_n = IDLE;
      en_n    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pll_lock) begin
            state_n  = DELAY;
            tmr_load = 1'b1;
            tmr_val  = DELAY_LOAD;
          end
        end
        DELAY: begin
          if (tmr_expire) begin
            tmr_load = 1'b1;
            if (first_stg[SW]) begin
              state_n = RUN;
              cur_n   = first_stg[SW-1:0];
              en_n    = onehot(first_stg[SW-1:0]);
              tmr_val = TIMEOUT_LOAD;
            end else begin
              state_n = SETTLE;
              tmr_val = SETTLE_LOAD;
            end
          end
        end
        RUN: begin
          if (stage_en == '0) begin
            // Gap cycle after a completion: enable the stage chosen last cycle.
            en_n     = onehot(cur_q);
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LOAD;
          end else if (done_hit) begin
            // Checked before the timeout so a same-cycle done wins.
            en_n = '0;
            if (next_stg[SW]) begin
              cur_n = next_stg[SW-1:0];
            end else begin
              state_n  = SETTLE;
              tmr_load = 1'b1;
              tmr_val  = SETTLE_LOAD;
            end
          end else if ((TIMEOUT != 0) && tmr_expire) begin
            state_n = ERROR;
            en_n    = '0;
            err_n   = 1'b1;
            est_n   = cur_q;
          end
        end
        SETTLE: begin
          if (tmr_expire) state_n = READY;
        end
        READY: begin
          state_n = READY;
        end
        ERROR: begin
          if (retry) begin
            state_n  = DELAY;
            err_n    = 1'b0;
            est_n    = '0;
            tmr_load = 1'b1;
            tmr_val  = DELAY_LOAD;
          end
        end
        default: begin
          state_n = IDLE;
          en_n    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      stage_en      <= '0;
      stage_reset_n <= 1'b0;
      system_ready  <= 1'b0;
      error         <= 1'b0;
      error_stage   <= '0;
    end else begin
      state_q       <= state_n;
      cur_q         <= cur_n;
      stage_en      <= en_n;
      stage_reset_n <= (state_n != IDLE) && (state_n != DELAY);
      system_ready  <= (state_n == READY);
      error         <= err_n;
      error_stage   <= est_n;
    end
  end

  assign state = state_q;

endmodule

// File: doc/init_sequencer.md
INIT_SEQUENCER -- requirements
Module: init_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: number of handshaked init stages (1..8).
REQ-002 SHALL have parameter POWERUP_DELAY, default 32: cycles stage_reset_n is held low after pll_lock rises (1..65535).
REQ-003 SHALL have parameter SETTLE_DELAY, default 32: cycles between the last stage done and system_ready (0..65535).
REQ-004 SHALL have parameter TIMEOUT, default 1000: max cycles per stage awaiting done; 0 disables the timeout.
REQ-005 SHALL have parameter STAGE_SKIP, default 0 (NUM_STAGES bits): bit i set means stage i is bypassed.
REQ-006 SHALL have port clk, input, 1: the only clock.
REQ-007 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port pll_lock, input, 1: sequence gate, level-sensitive.
REQ-009 SHALL have port retry, input, 1: single-cycle pulse that restarts from ERROR.
REQ-010 SHALL have port stage_done, input, NUM_STAGES: per-stage completion level.
REQ-011 SHALL have port stage_en, output, NUM_STAGES: one-hot-or-zero stage enable.
REQ-012 SHALL have port stage_reset_n, output, 1: synchronous reset released to the stage logic.
REQ-013 SHALL have port system_ready, output, 1: global ready / reset release.
REQ-014 SHALL have port error, output, 1: sticky timeout flag.
REQ-015 SHALL have port error_stage, output, $clog2(NUM_STAGES) (min 1): index of the stage that timed out.
REQ-016 SHALL have port state, output, 3: current FSM state encoding, for debug.

Function
REQ-017 SHALL implement states IDLE, DELAY, RUN, SETTLE, READY, ERROR; all outputs registered.
REQ-018 IDLE: stage_reset_n=0, stage_en=0; pll_lock=1 -> DELAY next cycle.
REQ-019 DELAY: stage_reset_n=0 for exactly POWERUP_DELAY cycles, then RUN at the first non-skipped stage; if all stages are skipped, go to SETTLE.
REQ-020 In every state other than IDLE and DELAY, stage_reset_n SHALL be 1.
REQ-021 RUN at stage i: stage_en[i]=1 from the first RUN cycle, all other bits 0.
REQ-022 stage_done[i] SHALL be sampled only while stage_en[i]=1; done bits of other stages are ignored.
REQ-023 On a sampled done, stage_en SHALL be 0 the next cycle and advance to the next non-skipped stage the cycle after; after the last stage, go to SETTLE.
REQ-024 Per-stage timeout counter SHALL clear on stage entry; if TIMEOUT is non-zero and it reaches TIMEOUT without done -> ERROR, error=1, error_stage=i, stage_en=0.
REQ-025 If done and timeout occur in the same cycle, done SHALL win.
REQ-026 SETTLE SHALL last SETTLE_DELAY cycles, then READY with system_ready=1; when SETTLE_DELAY=0, READY follows the next cycle.
REQ-027 READY and ERROR SHALL be sticky, except as stated in REQ-028 and REQ-029.
REQ-028 retry in ERROR SHALL clear error and error_stage and go to DELAY; retry in any other state SHALL be ignored.
REQ-029 pll_lock=0 in any state other than IDLE SHALL go to IDLE next cycle, forcing stage_en=0, stage_reset_n=0, system_ready=0; error SHALL be kept.
REQ-030 pll_lock=0 has priority over retry, done and timeout.
REQ-031 Counters SHALL be 16 bits and SHALL saturate, never wrap.

Reset
REQ-032 reset_n=0 on a clk edge SHALL force IDLE, stage_en=0, stage_reset_n=0, system_ready=0, error=0, error_stage=0 and all counters to 0.
REQ-033 Reset SHALL override every input, including in mid-stage.

Structure
REQ-034 Package init_seq_pkg SHALL hold the state enum (IDLE=0 .. ERROR=5) and the 16-bit counter-width constant.
REQ-035 A single sub-module, delay_timer (load/enable/expire, 16-bit), SHALL be reused for the DELAY, SETTLE and timeout counts.

Verification
REQ-036 Scenario: defaults, pll_lock at cycle 0, each done 5 cycles after its enable -> stage_reset_n rises at cycle 33, stage_en walks 001/010/100, system_ready=1 32 cycles after the last done.
REQ-037 Scenario: stage 1 done never asserts -> at 1000 cycles error=1, error_stage=1, stage_en=0; retry -> DELAY, error=0.
REQ-038 Scenario: pll_lock drops mid-stage 2 -> IDLE next cycle, all outputs at reset values; relock reruns the full sequence.
REQ-039 Scenario: STAGE_SKIP=3'b010 -> stage_en never shows 010; stage 2 follows stage 0.
REQ-040 Scenario: stage_done=3'b111 held from cycle 0 -> each stage completes 1 cycle after its enable and stale done bits are ignored.
REQ-041 Scenario: done on the cycle timeout expires -> no error, advance; reset_n=0 mid-RUN -> IDLE next cycle.
